jtdsp16_xaau: RTL and testbench

JTDSP16_XAAU -- requirements
Module: jtdsp16_xaau

---
 rtl/jtdsp16_pkg.sv | 32 +++
 rtl/jtdsp16_xaau.sv | 155 +++++++++++++++
 tb/tb_jtdsp16_xaau.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/jtdsp16_pkg.sv
// Shared jtdsp16 constants: branch B-field codes, register selects and default vectors.
// Imported by the program-address unit and the control stage.
package jtdsp16_pkg;

  localparam logic [2:0] B_RETURN  = 3'b000;
  localparam logic [2:0] B_IRETURN = 3'b001;
  localparam logic [2:0] B_GOTO_PT = 3'b010;
  localparam logic [2:0] B_CALL_PT = 3'b011;

  localparam logic [1:0] SEL_PT = 2'b00;
  localparam logic [1:0] SEL_PR = 2'b01;
  localparam logic [1:0] SEL_PI = 2'b10;
  localparam logic [1:0] SEL_I  = 2'b11;

  localparam logic [15:0] DEF_IRQ_VEC   = 16'h0001;
  localparam logic [15:0] DEF_ICALL_VEC = 16'h0002;

  typedef enum logic [2:0] {
    PC_ADV,
    PC_JA,
    PC_PR,
    PC_PI,
    PC_PT,
    PC_ICALL,
    PC_IRQ
  } pc_src_e;

  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

endpackage

// File: rtl/jtdsp16_xaau.sv
// Program address arithmetic unit: PC sequencing, branch/call/return, interrupts,
// and the PT/PR/PI/i pointer registers.
module jtdsp16_xaau
  import jtdsp16_pkg::*;
#(
  parameter logic [15:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [15:0] ICALL_VEC = DEF_ICALL_VEC
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        goto_ja,
  input  logic        goto_b,
  input  logic        call_ja,
  input  logic        icall,
  input  logic        post_inc,
  input  logic [11:0] ifield,
  input  logic        con_result,
  input  logic        ext_irq,
  input  logic        reg_load,
  input  logic [1:0]  reg_sel,
  input  logic [15:0] reg_din,
  output logic [15:0] rom_addr,
  output logic [15:0] pt,
  output logic [15:0] pr,
  output logic [15:0] pi,
  output logic [11:0] i_reg,
  output logic        in_irq,
  output logic        irq_ack
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] pr_q, pr_d;
  logic [15:0] pi_q, pi_d;
  logic [15:0] pt_q, pt_d;
  logic [11:0] i_q, i_d;
  logic        in_irq_q, in_irq_d;
  logic        irq_ack_q, irq_ack_d;

  logic [15:0] pc_inc;
  logic [15:0] ja_tgt;
  logic [2:0]  b_fld;
  pc_src_e     pc_src;
  logic        link;

  // PC source selection; a pending ext_irq simply waits here until no strobe
  // is present and in_irq is clear, so no pending flag is stored.
  always_comb begin
    pc_inc = pc_q + 16'd1;
    ja_tgt = {pc_q[15:12], ifield};
    b_fld  = ifield[10:8];
    pc_src = PC_ADV;
    link   = 1'b0;
    if (icall) begin
      pc_src = PC_ICALL;
    end else if (call_ja) begin
      if (con_result) begin
        pc_src = PC_JA;
        link   = 1'b1;
      end
    end else if (goto_b) begin
      if (con_result) begin
        case (b_fld)
          B_RETURN:  pc_src = PC_PR;
          B_IRETURN: pc_src = PC_PI;
          B_GOTO_PT: pc_src = PC_PT;
          B_CALL_PT: begin
            pc_src = PC_PT;
            link   = 1'b1;
          end
          default:   pc_src = PC_ADV;
        endcase
      end
    end else if (goto_ja) begin
      if (con_result) pc_src = PC_JA;
    end else if (ext_irq && !in_irq_q) begin
      pc_src = PC_IRQ;
    end
  end

  // Register writes: reg_load first, then post_inc, then control-flow writes
  // override so branch/interrupt linkage wins over a same-cycle load.
  always_comb begin
    pc_d      = pc_q;
    pr_d      = pr_q;
    pi_d      = pi_q;
    pt_d      = pt_q;
    i_d       = i_q;
    in_irq_d  = in_irq_q;
    irq_ack_d = irq_ack_q;
    if (cen) begin
      case (pc_src)
        PC_JA:    pc_d = ja_tgt;
        PC_PR:    pc_d = pr_q;
        PC_PI:    pc_d = pi_q;
        PC_PT:    pc_d = pt_q;
        PC_ICALL: pc_d = ICALL_VEC;
        PC_IRQ:   pc_d = IRQ_VEC;
        default:  pc_d = pc_inc;
      endcase

      if (reg_load) begin
        case (reg_sel)
          SEL_PT:  pt_d = reg_din;
          SEL_PR:  pr_d = reg_din;
          SEL_PI:  pi_d = reg_din;
          default: i_d  = reg_din[11:0];
        endcase
      end

      if (post_inc && !(reg_load && reg_sel == SEL_PT))
        pt_d = pt_q + sext12(i_q);

      if (link) pr_d = pc_inc;

      if (pc_src == PC_ICALL || pc_src == PC_IRQ) begin
        pi_d     = pc_q;
        in_irq_d = 1'b1;
      end else if (pc_src == PC_PI) begin
        in_irq_d = 1'b0;
      end

      irq_ack_d = (pc_src == PC_IRQ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= 16'h0000;
      pr_q      <= 16'h0000;
      pi_q      <= 16'h0000;
      pt_q      <= 16'h0000;
      i_q       <= 12'h000;
      in_irq_q  <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pr_q      <= pr_d;
      pi_q      <= pi_d;
      pt_q      <= pt_d;
      i_q       <= i_d;
      in_irq_q  <= in_irq_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  assign rom_addr = pc_q;
  assign pt       = pt_q;
  assign pr       = pr_q;
  assign pi       = pi_q;
  assign i_reg    = i_q;
  assign in_irq   = in_irq_q;
  assign irq_ack  = irq_ack_q;

endmodule

// File: tb/tb_jtdsp16_xaau.sv
// Directed bench for jtdsp16_xaau: sequencing, branches, interrupts, PT stepping.
module tb_jtdsp16_xaau;

  logic        rst, clk, cen;
  logic        goto_ja, goto_b, call_ja, icall, post_inc;
  logic [11:0] ifield;
  logic        con_result, ext_irq;
  logic        reg_load;
  logic [1:0]  reg_sel;
  logic [15:0] reg_din;
  logic [15:0] rom_addr, pt, pr, pi;
  logic [11:0] i_reg;
  logic        in_irq, irq_ack;

  int n_assert = 0;
  int n_fail   = 0;

  jtdsp16_xaau dut (
    .rst(rst), .clk(clk), .cen(cen),
    .goto_ja(goto_ja), .goto_b(goto_b), .call_ja(call_ja), .icall(icall),
    .post_inc(post_inc), .ifield(ifield), .con_result(con_result),
    .ext_irq(ext_irq), .reg_load(reg_load), .reg_sel(reg_sel), .reg_din(reg_din),
    .rom_addr(rom_addr), .pt(pt), .pr(pr), .pi(pi), .i_reg(i_reg),
    .in_irq(in_irq), .irq_ack(irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    goto_ja = 0; goto_b = 0; call_ja = 0; icall = 0; post_inc = 0;
    ifield = 12'h000; con_result = 0; reg_load = 0; reg_sel = 2'b00; reg_din = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load PT with v, then goto pt; checks PC landed on v
  task automatic set_pc(input logic [15:0] v);
    idle();
    reg_load = 1; reg_sel = 2'b00; reg_din = v;
    tick();
    idle();
    goto_b = 1; con_result = 1; ifield = 12'h200;
    tick();
    idle();
    chk("set_pc", rom_addr, v);
  endtask

  initial begin
    rst = 1; cen = 1; ext_irq = 0;
    idle();
    tick(); tick();
    chk("rst_pc", rom_addr, 16'h0000);
    chk("rst_pr", pr, 16'h0000);
    chk("rst_pi", pi, 16'h0000);
    chk("rst_pt", pt, 16'h0000);
    chk("rst_i", {4'h0, i_reg}, 16'h0000);
    chk("rst_inirq", {15'd0, in_irq}, 16'd0);
    chk("rst_ack", {15'd0, irq_ack}, 16'd0);
    rst = 0;
    tick();
    chk("adv_from_0", rom_addr, 16'h0001);

    // wrap
    set_pc(16'hFFFE);
    tick();
    chk("wrap_ffff", rom_addr, 16'hFFFF);
    tick();
    chk("wrap_0000", rom_addr, 16'h0000);

    // call/return
    set_pc(16'h3120);
    call_ja = 1; con_result = 1; ifield = 12'h456;
    tick(); idle();
    chk("call_pc", rom_addr, 16'h3456);
    chk("call_pr", pr, 16'h3121);
    goto_b = 1; con_result = 1; ifield = 12'h000;
    tick(); idle();
    chk("ret_pc", rom_addr, 16'h3121);

    // false condition
    set_pc(16'h0010);
    goto_ja = 1; con_result = 0; ifield = 12'h800;
    tick(); idle();
    chk("false_pc", rom_addr, 16'h0011);
    chk("false_pr", pr, 16'h3121);

    // reserved B code: plain advance
    goto_b = 1; con_result = 1; ifield = 12'h400;
    tick(); idle();
    chk("bres_pc", rom_addr, 16'h0012);

    // call pt via B=011
    set_pc(16'h0500);
    reg_load = 1; reg_sel = 2'b00; reg_din = 16'h0700;
    tick(); idle();
    goto_b = 1; con_result = 1; ifield = 12'h300;
    tick(); idle();
    chk("callpt_pc", rom_addr, 16'h0700);
    chk("callpt_pr", pr, 16'h0502);

    // strobe priority: call_ja beats goto_ja; link beats same-cycle PR load
    set_pc(16'h2000);
    call_ja = 1; goto_ja = 1; con_result = 1; ifield = 12'h0AB;
    reg_load = 1; reg_sel = 2'b01; reg_din = 16'hBEEF;
    tick(); idle();
    chk("prio_pc", rom_addr, 16'h20AB);
    chk("prio_pr", pr, 16'h2001);

    // interrupt entry/exit
    set_pc(16'h0040);
    ext_irq = 1;
    tick();
    chk("irq_pc", rom_addr, 16'h0001);
    chk("irq_pi", pi, 16'h0040);
    chk("irq_ack1", {15'd0, irq_ack}, 16'd1);
    chk("irq_in1", {15'd0, in_irq}, 16'd1);
    tick();
    chk("irq_nest_pc", rom_addr, 16'h0002);
    chk("irq_ack0", {15'd0, irq_ack}, 16'd0);
    chk("irq_nest_pi", pi, 16'h0040);
    ext_irq = 0;
    goto_b = 1; con_result = 1; ifield = 12'h100;
    tick(); idle();
    chk("iret_pc", rom_addr, 16'h0040);
    chk("iret_in", {15'd0, in_irq}, 16'd0);

    // deferral behind a branch
    goto_ja = 1; con_result = 1; ifield = 12'h234; ext_irq = 1;
    tick(); idle();
    chk("defer_pc", rom_addr, 16'h0234);
    chk("defer_in", {15'd0, in_irq}, 16'd0);
    chk("defer_ack", {15'd0, irq_ack}, 16'd0);
    tick();
    chk("defer_irq_pc", rom_addr, 16'h0001);
    chk("defer_irq_pi", pi, 16'h0234);
    ext_irq = 0;
    // icall while in service overwrites PI
    icall = 1;
    tick(); idle();
    chk("icall_pc", rom_addr, 16'h0002);
    chk("icall_pi", pi, 16'h0001);
    chk("icall_in", {15'd0, in_irq}, 16'd1);
    goto_b = 1; con_result = 1; ifield = 12'h100;
    tick(); idle();
    chk("icall_ret", rom_addr, 16'h0001);

    // PT step
    reg_load = 1; reg_sel = 2'b00; reg_din = 16'h0005;
    tick(); idle();
    reg_load = 1; reg_sel = 2'b11; reg_din = 16'hFFFE;
    tick(); idle();
    chk("i_load", {4'h0, i_reg}, 16'h0FFE);
    post_inc = 1;
    tick(); idle();
    chk("pt_neg", pt, 16'h0003);
    reg_load = 1; reg_sel = 2'b00; reg_din = 16'hFFFF;
    tick(); idle();
    reg_load = 1; reg_sel = 2'b11; reg_din = 16'h0001;
    tick(); idle();
    post_inc = 1;
    tick(); idle();
    chk("pt_wrap", pt, 16'h0000);
    post_inc = 1; reg_load = 1; reg_sel = 2'b00; reg_din = 16'h1234;
    tick(); idle();
    chk("pt_load_wins", pt, 16'h1234);

    // cen low freezes everything
    set_pc(16'h0800);
    cen = 0;
    goto_ja = 1; con_result = 1; ifield = 12'h0FF; ext_irq = 1;
    tick(); tick(); idle();
    chk("cen_pc", rom_addr, 16'h0800);
    chk("cen_in", {15'd0, in_irq}, 16'd0);
    cen = 1; ext_irq = 0;

    // mid-operation reset with a pending request
    ext_irq = 1; goto_ja = 1; con_result = 1; ifield = 12'h0FF;
    #2 rst = 1;
    #1;
    chk("mrst_pc", rom_addr, 16'h0000);
    chk("mrst_pr", pr, 16'h0000);
    tick();
    idle(); ext_irq = 0;
    rst = 0;
    chk("mrst_hold", rom_addr, 16'h0000);
    tick();
    chk("mrst_restart", rom_addr, 16'h0001);
    chk("mrst_in", {15'd0, in_irq}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
